// File: rtl/imem_load_arb.sv
// Instruction-memory port arbiter: a boot loader owns the memory in LOAD, then the
// CPU fetches in RUN while late loader writes are served with bounded starvation.
module imem_load_arb #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              cpu_hold,
    input  logic              ldr_valid,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    input  logic              ldr_last,
    output logic              ldr_ready,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W:0]   load_cnt,
    output logic              state_o
);

    localparam logic ST_LOAD = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam int CNT_W = ADDR_W + 1;
    localparam int SW    = $clog2(STARVE_MAX + 1);

    // One word per address: a full load is 2**ADDR_W writes.
    localparam logic [CNT_W-1:0] CNT_MAX    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [SW-1:0]    STARVE_LIM = SW'(STARVE_MAX);

    logic              state_q, state_d;
    logic [CNT_W-1:0]  load_cnt_q, load_cnt_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              cpu_grant;
    logic              ldr_grant;

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        starve_d   = starve_q;
        cpu_grant  = 1'b0;
        ldr_grant  = 1'b0;

        if (state_q == ST_LOAD) begin
            ldr_grant = ldr_valid;
            starve_d  = '0;
            if (ldr_valid) begin
                if (load_cnt_q != CNT_MAX) begin
                    load_cnt_d = load_cnt_q + CNT_W'(1);
                end
                if (ldr_last || (load_cnt_d == CNT_MAX)) begin
                    state_d = ST_RUN;
                end
            end
        end else begin
            // CPU wins ties until the loader has been refused STARVE_MAX times in a row.
            ldr_grant = ldr_valid && (!cpu_req || (starve_q == STARVE_LIM));
            cpu_grant = cpu_req && !ldr_grant;

            if (ldr_valid && !ldr_grant) begin
                if (starve_q != STARVE_LIM) begin
                    starve_d = starve_q + SW'(1);
                end
            end else begin
                starve_d = '0;
            end

            if (reload) begin
                state_d    = ST_LOAD;
                load_cnt_d = '0;
                starve_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            load_cnt_q <= '0;
            starve_q   <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            starve_q   <= starve_d;
        end
    end

    // Handshake outputs are gated by rst so reset takes effect without waiting for a clock.
    always_comb begin
        cpu_hold  = rst || (state_q == ST_LOAD);
        cpu_ready = !rst && cpu_grant;
        ldr_ready = !rst && ((state_q == ST_LOAD) || ldr_grant);
        mem_we    = !rst && ldr_grant;
        mem_addr  = ((state_q == ST_LOAD) || ldr_grant) ? ldr_addr : cpu_addr;
        mem_wdata = ldr_wdata;
        cpu_rdata = mem_rdata;
    end

    assign load_cnt = load_cnt_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_imem_load_arb.sv
// Bench for imem_load_arb: directed boot/patch/contention/reload/reset steps plus
// random traffic, checked against a transaction-level model and a golden memory image.
module tb_imem_load_arb;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 16;
    localparam int STARVE_MAX = 4;
    localparam int DEPTH      = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;
    logic              cpu_hold;
    logic              ldr_valid;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic              ldr_last;
    logic              ldr_ready;
    logic              reload;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W:0]   load_cnt;
    logic              dbg_state;

    logic [DATA_W-1:0] mem  [DEPTH] = '{default: '0};
    logic [DATA_W-1:0] gold [DEPTH] = '{default: '0};

    int checks = 0;
    int errors = 0;

    // Model state: operating mode, words loaded, consecutive loader refusals.
    bit m_run    = 1'b0;
    int m_cnt    = 0;
    int m_starve = 0;

    always #5 clk = ~clk;

    imem_load_arb #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready), .cpu_hold(cpu_hold),
        .ldr_valid(ldr_valid), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_last(ldr_last), .ldr_ready(ldr_ready), .reload(reload),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .load_cnt(load_cnt), .state_o(dbg_state)
    );

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ldr_wins();
        return ldr_valid && (!cpu_req || (m_starve >= STARVE_MAX));
    endfunction

    task automatic check_cycle();
        logic e_hold, e_cready, e_lready, e_we;
        if (rst) begin
            e_hold = 1'b1; e_cready = 1'b0; e_lready = 1'b0; e_we = 1'b0;
        end else if (!m_run) begin
            e_hold = 1'b1; e_cready = 1'b0; e_lready = 1'b1; e_we = ldr_valid;
        end else begin
            e_hold   = 1'b0;
            e_lready = model_ldr_wins();
            e_we     = e_lready;
            e_cready = cpu_req && !e_lready;
        end
        chk("cpu_hold", cpu_hold, e_hold);
        chk("cpu_ready", cpu_ready, e_cready);
        chk("mem_we", mem_we, e_we);
        if (rst || !m_run || ldr_valid) chk("ldr_ready", ldr_ready, e_lready);
        chk("load_cnt", load_cnt, rst ? 0 : m_cnt);
        chk("ready_excl", cpu_ready & ldr_ready, 1'b0);
        chk("rdata_pass", cpu_rdata, mem_rdata);
        if (e_we) begin
            chk("wr_addr", mem_addr, ldr_addr);
            chk("wr_data", mem_wdata, ldr_wdata);
        end else if (m_run && !rst) begin
            chk("rd_addr", mem_addr, cpu_addr);
        end
        if (e_cready) chk("fetch_data", cpu_rdata, gold[cpu_addr]);
    endtask

    task automatic model_update();
        bit lg;
        if (rst) begin
            m_run = 1'b0; m_cnt = 0; m_starve = 0;
            return;
        end
        if (!m_run) begin
            m_starve = 0;
            if (ldr_valid) begin
                gold[ldr_addr] = ldr_wdata;
                if (m_cnt < DEPTH) m_cnt++;
                if (ldr_last || m_cnt == DEPTH) m_run = 1'b1;
            end
        end else begin
            lg = model_ldr_wins();
            if (lg) begin
                gold[ldr_addr] = ldr_wdata;
                m_starve = 0;
            end else if (ldr_valid) begin
                m_starve++;
            end else begin
                m_starve = 0;
            end
            if (reload) begin
                m_run = 1'b0; m_cnt = 0; m_starve = 0;
            end
        end
    endtask

    task automatic settle();
        #2;
        check_cycle();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; ldr_valid = 1'b0; ldr_last = 1'b0; reload = 1'b0;
    endtask

    task automatic ldr_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             input logic last);
        ldr_valid = 1'b1; ldr_addr = a; ldr_wdata = d; ldr_last = last;
        settle();
        advance();
        ldr_valid = 1'b0; ldr_last = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] word0;
        rst = 1'b1;
        idle_inputs();
        cpu_addr = '0; ldr_addr = '0; ldr_wdata = '0;

        // Reset held: loader request must not reach memory.
        ldr_valid = 1'b1;
        settle(); advance();
        settle(); advance();
        ldr_valid = 1'b0;
        rst = 1'b0;

        // Boot load of 8 words.
        word0 = DATA_W'($urandom);
        for (int i = 0; i < 8; i++) begin
            ldr_write(ADDR_W'(i), (i == 0) ? word0 : DATA_W'($urandom), i == 7);
        end
        cpu_req = 1'b1; cpu_addr = '0;
        settle();
        chk("boot_hold", cpu_hold, 1'b0);
        chk("boot_cnt", load_cnt, 8);
        chk("boot_fetch0", cpu_rdata, word0);
        advance();

        // Patch while CPU is idle, then fetch it back.
        cpu_req = 1'b0;
        ldr_valid = 1'b1; ldr_addr = 8'd3; ldr_wdata = 16'h5805;
        settle();
        chk("patch_we", mem_we, 1'b1);
        advance();
        ldr_valid = 1'b0; cpu_req = 1'b1; cpu_addr = 8'd3;
        settle();
        chk("patch_fetch", cpu_rdata, 16'h5805);
        advance();

        // Continuous contention: loader wins every fifth cycle.
        for (int i = 0; i < 15; i++) begin
            cpu_req = 1'b1; ldr_valid = 1'b1;
            cpu_addr = ADDR_W'($urandom); ldr_addr = ADDR_W'($urandom_range(8, 255));
            ldr_wdata = DATA_W'($urandom);
            settle();
            chk("contend_cpu", cpu_ready, (i % 5) != 4);
            chk("contend_ldr", ldr_ready, (i % 5) == 4);
            advance();
        end
        idle_inputs();
        settle(); advance();

        // Random traffic with occasional reloads and load terminations.
        for (int i = 0; i < 400; i++) begin
            cpu_req   = 1'($urandom_range(0, 1));
            ldr_valid = 1'($urandom_range(0, 2) == 0);
            cpu_addr  = ADDR_W'($urandom);
            ldr_addr  = ADDR_W'($urandom);
            ldr_wdata = DATA_W'($urandom);
            ldr_last  = 1'($urandom_range(0, 5) == 0);
            reload    = 1'($urandom_range(0, 39) == 0);
            settle(); advance();
        end
        idle_inputs();
        if (!m_run) ldr_write(ADDR_W'($urandom), DATA_W'($urandom), 1'b1);

        // Reload pulse alongside a fetch.
        reload = 1'b1; cpu_req = 1'b1; cpu_addr = ADDR_W'($urandom);
        settle();
        chk("reload_fetch", cpu_ready, 1'b1);
        advance();
        idle_inputs();
        settle();
        chk("reload_hold", cpu_hold, 1'b1);
        chk("reload_cnt", load_cnt, 0);
        chk("reload_lrdy", ldr_ready, 1'b1);
        advance();

        // Full load without ldr_last, then one write in RUN.
        for (int i = 0; i < DEPTH; i++) begin
            ldr_write(ADDR_W'(i), DATA_W'($urandom), 1'b0);
        end
        settle();
        chk("full_cnt", load_cnt, 256);
        chk("full_hold", cpu_hold, 1'b0);
        advance();
        ldr_valid = 1'b1; ldr_addr = 8'd5; ldr_wdata = DATA_W'($urandom);
        settle();
        chk("extra_we", mem_we, 1'b1);
        advance();
        ldr_valid = 1'b0; cpu_req = 1'b1; cpu_addr = 8'd5;
        settle();
        chk("extra_cnt", load_cnt, 256);
        advance();

        // Asynchronous reset between edges during a load.
        idle_inputs();
        reload = 1'b1;
        settle(); advance();
        reload = 1'b0;
        for (int i = 0; i < 3; i++) ldr_write(ADDR_W'(40 + i), DATA_W'($urandom), 1'b0);
        ldr_valid = 1'b1; ldr_addr = 8'd43; ldr_wdata = DATA_W'($urandom);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_we", mem_we, 1'b0);
        chk("arst_cnt", load_cnt, 0);
        chk("arst_lrdy", ldr_ready, 1'b0);
        chk("arst_hold", cpu_hold, 1'b1);
        settle(); advance();
        rst = 1'b0; ldr_valid = 1'b0;
        settle();
        chk("post_rst_lrdy", ldr_ready, 1'b1);
        chk("post_rst_cnt", load_cnt, 0);
        advance();
        ldr_write(8'd0, DATA_W'($urandom), 1'b1);
        cpu_req = 1'b1; cpu_addr = 8'd0;
        settle(); advance();
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
